// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for stage E: radix-2^MUL_BITS shift-add multiply,
// radix-2 restoring divide, sign fix-up and optional 2W-bit accumulate in a final FIX cycle.
module mul_div_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic                 acc_en,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic                 flush,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [WIDTH-1:0]     result_lo,
    output logic [WIDTH-1:0]     result_hi,
    output logic [1:0]           nz
);

    localparam int N_MUL = WIDTH / MUL_BITS;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(N_MUL - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_neg_dw(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_op;
    logic                   r_acc_en;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_mag;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic                   r_special;
    logic                   r_done;
    logic [WIDTH-1:0]       r_result;
    logic [WIDTH-1:0]       r_result_lo;
    logic [WIDTH-1:0]       r_result_hi;
    logic [1:0]             r_nz;

    logic                   w_accept;
    logic                   w_sa;
    logic                   w_sb;
    logic                   w_neg_a;
    logic                   w_neg_b;
    logic                   w_div_zero;
    logic                   w_div_ovf;
    logic                   w_special;
    logic [MUL_BITS-1:0]    w_digit;
    logic [WIDTH+MUL_BITS-1:0] w_pp;
    logic [WIDTH+MUL_BITS-1:0] w_sum;
    logic [WIDTH-1:0]       w_mul_lo;
    logic [WIDTH:0]         w_shift;
    logic [WIDTH-1:0]       w_diff;
    logic                   w_ge;
    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH-1:0]       w_quo;
    logic [WIDTH-1:0]       w_rem;
    logic [WIDTH-1:0]       w_fix_lo;
    logic [WIDTH-1:0]       w_fix_hi;
    logic [WIDTH-1:0]       w_fix_res;

    assign w_accept = start && !flush && (r_state == S_IDLE);

    // Operand signedness: MUL/MULH fully signed, MULHSU only a, MULHU unsigned; DIV/REM signed.
    assign w_sa    = op[2] ? ~op[0] : (op != 3'b011);
    assign w_sb    = op[2] ? ~op[0] : ~op[1];
    assign w_neg_a = w_sa & a[WIDTH-1];
    assign w_neg_b = w_sb & b[WIDTH-1];

    assign w_div_zero = (b == '0);
    assign w_div_ovf  = w_sa && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    assign w_special  = op[2] && (w_div_zero || w_div_ovf);

    // One multiply step: add magnitude times the next digit, then shift the pair right.
    assign w_digit  = r_lo[MUL_BITS-1:0];
    assign w_pp     = {{MUL_BITS{1'b0}}, r_mag} * {{WIDTH{1'b0}}, w_digit};
    assign w_sum    = w_pp + {{MUL_BITS{1'b0}}, r_hi};
    assign w_mul_lo = WIDTH'({w_sum[MUL_BITS-1:0], r_lo} >> MUL_BITS);

    // One restoring divide step: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_mag});
    assign w_diff  = w_shift[WIDTH-1:0] - r_mag;

    always_comb begin
        w_prod    = f_neg_dw({r_hi, r_lo}, r_neg_q) + (r_acc_en ? r_acc : '0);
        w_quo     = r_special ? r_lo : f_neg_w(r_lo, r_neg_q);
        w_rem     = r_special ? r_hi : f_neg_w(r_hi, r_neg_r);
        w_fix_lo  = r_op[2] ? w_quo : w_prod[WIDTH-1:0];
        w_fix_hi  = r_op[2] ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        if (r_op[2]) begin
            w_fix_res = r_op[1] ? w_fix_hi : w_fix_lo;
        end else begin
            w_fix_res = (r_op[1:0] == 2'b00) ? w_fix_lo : w_fix_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (!op[2])         w_state_nxt = S_MUL;
                        else if (w_special) w_state_nxt = S_FIX;
                        else                w_state_nxt = S_DIV;
                    end
                end
                S_MUL:   if (r_cnt == MUL_LAST) w_state_nxt = S_FIX;
                S_DIV:   if (r_cnt == DIV_LAST) w_state_nxt = S_FIX;
                S_FIX:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op      <= op;
            r_acc_en  <= acc_en & ~op[2];
            r_acc     <= acc;
            r_cnt     <= '0;
            r_neg_q   <= w_neg_a ^ w_neg_b;
            r_neg_r   <= w_neg_a;
            r_special <= w_special;
            if (!op[2]) begin
                r_mag <= f_mag(a, w_sa);
                r_lo  <= f_mag(b, w_sb);
                r_hi  <= '0;
            end else if (w_div_zero) begin
                r_mag <= '0;
                r_lo  <= '1;
                r_hi  <= a;
            end else if (w_div_ovf) begin
                r_mag <= '0;
                r_lo  <= a;
                r_hi  <= '0;
            end else begin
                r_mag <= f_mag(b, w_sb);
                r_lo  <= f_mag(a, w_sa);
                r_hi  <= '0;
            end
        end else if (r_state == S_MUL) begin
            r_hi  <= w_sum[WIDTH+MUL_BITS-1:MUL_BITS];
            r_lo  <= w_mul_lo;
            r_cnt <= r_cnt + CW'(1);
        end else if (r_state == S_DIV) begin
            r_hi  <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_lo  <= {r_lo[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Results commit only in FIX; a flush in FIX suppresses the commit as well as done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_lo <= '0;
            r_result_hi <= '0;
            r_nz        <= 2'b01;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_FIX && !flush) begin
                r_done      <= 1'b1;
                r_result    <= w_fix_res;
                r_result_lo <= w_fix_lo;
                r_result_hi <= w_fix_hi;
                r_nz        <= {w_fix_res[WIDTH-1], (w_fix_res == '0)};
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign result    = r_result;
    assign result_lo = r_result_lo;
    assign result_hi = r_result_hi;
    assign nz        = r_nz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed results, latencies, specials, flush and reset.
module tb_mul_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [2:0]     op;
    logic           acc_en;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] acc;
    logic           flush;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic [W-1:0]   result_lo;
    logic [W-1:0]   result_hi;
    logic [1:0]     nz;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int seen_done;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W), .MUL_BITS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .acc_en(acc_en),
        .a(a), .b(b), .acc(acc), .flush(flush), .busy(busy), .done(done),
        .result(result), .result_lo(result_lo), .result_hi(result_hi), .nz(nz)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic ae, input logic [2*W-1:0] vacc, output int cycles);
        op = o; a = va; b = vb; acc_en = ae; acc = vacc; start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; acc_en = 1'b0;
        a = '0; b = '0; acc = '0; flush = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_lo", result_lo, 0);
        chk("rst_hi", result_hi, 0);
        chk("rst_nz", nz, 2'b01);

        issue(3'b000, 32'd7, 32'hFFFFFFFD, 1'b0, '0, lat);
        chk("mul_lat", lat, 9);
        chk("mul_res", result, 32'hFFFFFFEB);
        chk("mul_hi", result_hi, 32'hFFFFFFFF);
        chk("mul_nz", nz, 2'b10);
        chk("mul_busy_at_done", busy, 0);

        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0, lat);
        chk("mulhu_res", result, 32'hFFFFFFFE);
        chk("mulhu_lo", result_lo, 32'h00000001);

        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0, lat);
        chk("mulhsu_res", result, 32'hFFFFFFFF);
        chk("mulhsu_lo", result_lo, 32'h00000001);

        issue(3'b001, 32'h80000000, 32'h80000000, 1'b0, '0, lat);
        chk("mulh_min_res", result, 32'h40000000);
        chk("mulh_min_lo", result_lo, 32'h0);

        issue(3'b100, 32'hFFFFFFF9, 32'd2, 1'b0, '0, lat);
        chk("div_lat", lat, 33);
        chk("div_res", result, 32'hFFFFFFFD);
        chk("div_rem_hi", result_hi, 32'hFFFFFFFF);

        issue(3'b110, 32'hFFFFFFF9, 32'd2, 1'b0, '0, lat);
        chk("rem_res", result, 32'hFFFFFFFF);
        chk("rem_nz", nz, 2'b10);

        issue(3'b101, 32'd100, 32'd7, 1'b1, 64'h1234, lat);
        chk("divu_res", result, 32'd14);
        chk("divu_hi", result_hi, 32'd2);

        issue(3'b111, 32'd100, 32'd7, 1'b0, '0, lat);
        chk("remu_res", result, 32'd2);

        issue(3'b100, 32'd5, 32'd0, 1'b0, '0, lat);
        chk("div0_lat", lat, 1);
        chk("div0_res", result, 32'hFFFFFFFF);
        chk("div0_hi", result_hi, 32'd5);

        issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b0, '0, lat);
        chk("ovf_lat", lat, 1);
        chk("ovf_res", result, 32'h0);
        chk("ovf_nz", nz, 2'b01);
        chk("ovf_lo", result_lo, 32'h80000000);

        issue(3'b000, 32'd3, 32'd4, 1'b1, 64'h1_FFFFFFFF, lat);
        chk("mla_hi", result_hi, 32'd2);
        chk("mla_lo", result_lo, 32'h0000000B);

        chk("b2b_done_seen", done, 1);
        issue(3'b000, 32'd6, 32'd7, 1'b0, '0, lat);
        chk("b2b_lat", lat, 9);
        chk("b2b_res", result, 32'd42);

        // A start while busy must be dropped without disturbing the running multiply.
        op = 3'b000; a = 32'd2; b = 32'd3; acc_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("ign_busy", busy, 1);
        op = 3'b100; a = 32'd1; b = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 3;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        chk("ign_lat", lat, 9);
        chk("ign_res", result, 32'd6);

        op = 3'b100; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        seen_done = 0;
        repeat (40) begin
            tick();
            if (done) seen_done++;
        end
        chk("flush_no_done", seen_done, 0);
        chk("flush_res_hold", result, 32'd6);

        op = 3'b000; a = 32'd1; b = 32'd1; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", busy, 0);

        op = 3'b000; a = 32'd5; b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        chk("midrst_nz", nz, 2'b01);
        seen_done = 0;
        repeat (12) begin
            tick();
            if (done) seen_done++;
        end
        chk("midrst_no_done", seen_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
